// File: rtl/freelist_rls_sched.sv
// Release scheduler in front of the physical-register freelist: merges rollback and
// commit frees into an in-order FIFO and drains up to four per cycle to the freelist.
module freelist_rls_sched #(
  parameter int PIDX_W = 6,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_rb_vld_0,
  input  logic                       io_rb_vld_1,
  input  logic                       io_rb_vld_2,
  input  logic                       io_rb_vld_3,
  input  logic [PIDX_W-1:0]          io_rb_pidx_0,
  input  logic [PIDX_W-1:0]          io_rb_pidx_1,
  input  logic [PIDX_W-1:0]          io_rb_pidx_2,
  input  logic [PIDX_W-1:0]          io_rb_pidx_3,
  output logic                       io_rb_ready,
  input  logic                       io_cmt_vld_0,
  input  logic                       io_cmt_vld_1,
  input  logic                       io_cmt_vld_2,
  input  logic                       io_cmt_vld_3,
  input  logic [PIDX_W-1:0]          io_cmt_pidx_0,
  input  logic [PIDX_W-1:0]          io_cmt_pidx_1,
  input  logic [PIDX_W-1:0]          io_cmt_pidx_2,
  input  logic [PIDX_W-1:0]          io_cmt_pidx_3,
  output logic                       io_cmt_ready,
  input  logic                       io_fl_busy,
  output logic                       io_rls_0,
  output logic                       io_rls_1,
  output logic                       io_rls_2,
  output logic                       io_rls_3,
  output logic [PIDX_W-1:0]          io_rls_pidx_0,
  output logic [PIDX_W-1:0]          io_rls_pidx_1,
  output logic [PIDX_W-1:0]          io_rls_pidx_2,
  output logic [PIDX_W-1:0]          io_rls_pidx_3,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic                       io_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: each source presents a lane group; the whole group is taken at the
  // clock edge iff its ready is high, otherwise upstream holds it unchanged.
  logic [PIDX_W-1:0] mem_q [DEPTH];
  logic [PIDX_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d, wptr, rptr;
  logic [CW-1:0]     count_q, count_d, free, rem;
  logic [3:0]        rb_vld, cmt_vld, rls, enq;
  logic [PIDX_W-1:0] rb_pidx [4];
  logic [PIDX_W-1:0] cmt_pidx [4];
  logic [PIDX_W-1:0] rls_pidx [4];
  logic [2:0]        ndrain, nrb, ncmt;
  logic              rb_ready, cmt_ready;

  assign rb_vld      = {io_rb_vld_3, io_rb_vld_2, io_rb_vld_1, io_rb_vld_0};
  assign cmt_vld     = {io_cmt_vld_3, io_cmt_vld_2, io_cmt_vld_1, io_cmt_vld_0};
  assign rb_pidx[0]  = io_rb_pidx_0;
  assign rb_pidx[1]  = io_rb_pidx_1;
  assign rb_pidx[2]  = io_rb_pidx_2;
  assign rb_pidx[3]  = io_rb_pidx_3;
  assign cmt_pidx[0] = io_cmt_pidx_0;
  assign cmt_pidx[1] = io_cmt_pidx_1;
  assign cmt_pidx[2] = io_cmt_pidx_2;
  assign cmt_pidx[3] = io_cmt_pidx_3;

  // Space freed by this cycle's drain is reusable in the same cycle; rollback is served first.
  always_comb begin
    nrb       = 3'(rb_vld[0]) + 3'(rb_vld[1]) + 3'(rb_vld[2]) + 3'(rb_vld[3]);
    ncmt      = 3'(cmt_vld[0]) + 3'(cmt_vld[1]) + 3'(cmt_vld[2]) + 3'(cmt_vld[3]);
    ndrain    = io_fl_busy ? 3'd0 : ((count_q >= CW'(4)) ? 3'd4 : count_q[2:0]);
    free      = CW'(DEPTH) - count_q + CW'(ndrain);
    rb_ready  = (CW'(nrb) <= free);
    rem       = free - (rb_ready ? CW'(nrb) : '0);
    cmt_ready = (CW'(ncmt) <= rem);
  end

  always_comb begin
    rptr = head_q;
    for (int l = 0; l < 4; l++) begin
      rptr        = head_q + AW'(l);
      rls[l]      = (3'(l) < ndrain);
      rls_pidx[l] = rls[l] ? mem_q[rptr] : '0;
    end
  end

  // Accepted lanes are compacted: rollback lanes first, then commit lanes, each in lane order.
  always_comb begin
    mem_d = mem_q;
    enq   = '0;
    wptr  = tail_q;
    for (int i = 0; i < 4; i++) begin
      if (rb_ready && rb_vld[i]) begin
        wptr        = tail_q + AW'(enq);
        mem_d[wptr] = rb_pidx[i];
        enq         = enq + 4'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (cmt_ready && cmt_vld[i]) begin
        wptr        = tail_q + AW'(enq);
        mem_d[wptr] = cmt_pidx[i];
        enq         = enq + 4'd1;
      end
    end
    head_d  = head_q + AW'(ndrain);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + CW'(enq) - CW'(ndrain);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign io_rb_ready   = rb_ready;
  assign io_cmt_ready  = cmt_ready;
  assign io_rls_0      = rls[0];
  assign io_rls_1      = rls[1];
  assign io_rls_2      = rls[2];
  assign io_rls_3      = rls[3];
  assign io_rls_pidx_0 = rls_pidx[0];
  assign io_rls_pidx_1 = rls_pidx[1];
  assign io_rls_pidx_2 = rls_pidx[2];
  assign io_rls_pidx_3 = rls_pidx[3];
  assign io_count      = count_q;
  assign io_empty      = (count_q == '0);
endmodule

// File: tb/tb_freelist_rls_sched.sv
// Directed bench for freelist_rls_sched: drives lane groups after the falling edge and
// checks registered and combinational outputs against hand-computed values.
module tb_freelist_rls_sched;
  logic        clock, reset, busy;
  logic [3:0]  rb_vld, cmt_vld, rls;
  logic [23:0] rb_pidx, cmt_pidx, rp;
  logic        rb_ready, cmt_ready, empty;
  logic [4:0]  count;
  int          vec_cnt, err_cnt;

  freelist_rls_sched #(.PIDX_W(6), .DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .io_rb_vld_0(rb_vld[0]), .io_rb_vld_1(rb_vld[1]),
    .io_rb_vld_2(rb_vld[2]), .io_rb_vld_3(rb_vld[3]),
    .io_rb_pidx_0(rb_pidx[5:0]), .io_rb_pidx_1(rb_pidx[11:6]),
    .io_rb_pidx_2(rb_pidx[17:12]), .io_rb_pidx_3(rb_pidx[23:18]),
    .io_rb_ready(rb_ready),
    .io_cmt_vld_0(cmt_vld[0]), .io_cmt_vld_1(cmt_vld[1]),
    .io_cmt_vld_2(cmt_vld[2]), .io_cmt_vld_3(cmt_vld[3]),
    .io_cmt_pidx_0(cmt_pidx[5:0]), .io_cmt_pidx_1(cmt_pidx[11:6]),
    .io_cmt_pidx_2(cmt_pidx[17:12]), .io_cmt_pidx_3(cmt_pidx[23:18]),
    .io_cmt_ready(cmt_ready),
    .io_fl_busy(busy),
    .io_rls_0(rls[0]), .io_rls_1(rls[1]), .io_rls_2(rls[2]), .io_rls_3(rls[3]),
    .io_rls_pidx_0(rp[5:0]), .io_rls_pidx_1(rp[11:6]),
    .io_rls_pidx_2(rp[17:12]), .io_rls_pidx_3(rp[23:18]),
    .io_count(count), .io_empty(empty)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    rb_vld = '0; rb_pidx = '0; cmt_vld = '0; cmt_pidx = '0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push_cmt(input logic [3:0] v, input logic [23:0] p);
    cmt_vld = v; cmt_pidx = p;
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; busy = 1'b0; clear_inputs();
    #2;
    vec_cnt++;
    if ({rls, rp, count, empty} !== {4'b0, 24'b0, 5'd0, 1'b1}) begin
      err_cnt++;
      $display("FAIL reset_state: got rls=%b pidx=%h count=%0d empty=%b exp 0/0/0/1", rls, rp, count, empty);
    end
    tick();
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({rb_ready, cmt_ready} !== 2'b11) begin
      err_cnt++;
      $display("FAIL reset_ready: got %b exp 11", {rb_ready, cmt_ready});
    end
  endtask

  task automatic test_dense_commit();
    busy = 1'b0;
    cmt_vld = 4'b1111; cmt_pidx = pk(1, 2, 3, 4);
    #1;
    vec_cnt++;
    if (cmt_ready !== 1'b1) begin
      err_cnt++; $display("FAIL dense_ready: got %b exp 1", cmt_ready);
    end
    tick(); clear_inputs(); #1;
    vec_cnt++;
    if ({rls, rp} !== {4'b1111, pk(1, 2, 3, 4)}) begin
      err_cnt++; $display("FAIL dense_rls: got %b/%h exp 1111/%h", rls, rp, pk(1, 2, 3, 4));
    end
    tick(); #1;
    vec_cnt++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      err_cnt++; $display("FAIL dense_empty: got count=%0d empty=%b exp 0/1", count, empty);
    end
  endtask

  task automatic test_sparse_merge();
    busy = 1'b0;
    rb_vld = 4'b1010; rb_pidx = pk(0, 10, 0, 11);
    cmt_vld = 4'b0100; cmt_pidx = pk(0, 0, 20, 0);
    #1;
    vec_cnt++;
    if ({rb_ready, cmt_ready} !== 2'b11) begin
      err_cnt++; $display("FAIL sparse_ready: got %b exp 11", {rb_ready, cmt_ready});
    end
    tick(); clear_inputs(); #1;
    vec_cnt++;
    if ({rls, rp, count} !== {4'b0111, pk(10, 11, 20, 0), 5'd3}) begin
      err_cnt++;
      $display("FAIL sparse_rls: got %b/%h/%0d exp 0111/%h/3", rls, rp, count, pk(10, 11, 20, 0));
    end
    tick(); #1;
  endtask

  task automatic test_fill_wrap();
    logic [23:0] exp_p;
    busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cmt_vld = 4'b1111; cmt_pidx = pk(5 + 4*k, 6 + 4*k, 7 + 4*k, 8 + 4*k);
      #1;
      vec_cnt++;
      if (cmt_ready !== 1'b1) begin
        err_cnt++; $display("FAIL fill_ready_%0d: got %b exp 1", k, cmt_ready);
      end
      tick(); clear_inputs();
    end
    #1;
    vec_cnt++;
    if ({count, rls} !== {5'd16, 4'b0}) begin
      err_cnt++; $display("FAIL fill_full: got count=%0d rls=%b exp 16/0000", count, rls);
    end
    cmt_vld = 4'b0001; cmt_pidx = pk(63, 0, 0, 0);
    #1;
    vec_cnt++;
    if ({rb_ready, cmt_ready} !== 2'b10) begin
      err_cnt++; $display("FAIL full_block: got %b exp 10", {rb_ready, cmt_ready});
    end
    cmt_vld = 4'b0000;
    #1;
    vec_cnt++;
    if (cmt_ready !== 1'b1) begin
      err_cnt++; $display("FAIL full_empty_group: got %b exp 1", cmt_ready);
    end
    busy = 1'b0;
    for (int d = 0; d < 5; d++) begin
      if (d == 1) begin
        cmt_vld = 4'b1111; cmt_pidx = pk(30, 31, 32, 33);
      end
      #1;
      exp_p = (d < 4) ? pk(5 + 4*d, 6 + 4*d, 7 + 4*d, 8 + 4*d) : pk(30, 31, 32, 33);
      vec_cnt++;
      if ({rls, rp} !== {4'b1111, exp_p}) begin
        err_cnt++; $display("FAIL drain_%0d: got %b/%h exp 1111/%h", d, rls, rp, exp_p);
      end
      if (d == 1) begin
        vec_cnt++;
        if (cmt_ready !== 1'b1) begin
          err_cnt++; $display("FAIL wrap_push_ready: got %b exp 1", cmt_ready);
        end
      end
      tick(); clear_inputs();
    end
    #1;
    vec_cnt++;
    if ({count, empty, rls} !== {5'd0, 1'b1, 4'b0}) begin
      err_cnt++; $display("FAIL wrap_done: got count=%0d empty=%b rls=%b exp 0/1/0000", count, empty, rls);
    end
  endtask

  task automatic test_priority();
    logic [23:0] exp_p [5];
    logic [3:0]  exp_v [5];
    logic [4:0]  exp_c [5];
    exp_p[0] = pk(1, 2, 3, 4);    exp_v[0] = 4'b1111; exp_c[0] = 5'd16;
    exp_p[1] = pk(5, 6, 7, 8);    exp_v[1] = 4'b1111; exp_c[1] = 5'd13;
    exp_p[2] = pk(9, 10, 11, 12); exp_v[2] = 4'b1111; exp_c[2] = 5'd9;
    exp_p[3] = pk(13, 14, 40, 41); exp_v[3] = 4'b1111; exp_c[3] = 5'd5;
    exp_p[4] = pk(50, 0, 0, 0);   exp_v[4] = 4'b0001; exp_c[4] = 5'd1;
    busy = 1'b1;
    push_cmt(4'b1111, pk(1, 2, 3, 4));
    push_cmt(4'b1111, pk(5, 6, 7, 8));
    push_cmt(4'b1111, pk(9, 10, 11, 12));
    push_cmt(4'b0011, pk(13, 14, 0, 0));
    vec_cnt++;
    if (count !== 5'd14) begin
      err_cnt++; $display("FAIL prio_count14: got %0d exp 14", count);
    end
    rb_vld = 4'b0011; rb_pidx = pk(40, 41, 0, 0);
    cmt_vld = 4'b0001; cmt_pidx = pk(50, 0, 0, 0);
    #1;
    vec_cnt++;
    if ({rb_ready, cmt_ready} !== 2'b10) begin
      err_cnt++; $display("FAIL prio_ready: got %b exp 10", {rb_ready, cmt_ready});
    end
    tick();
    rb_vld = '0; rb_pidx = '0;
    #1;
    vec_cnt++;
    if ({count, cmt_ready} !== {5'd16, 1'b0}) begin
      err_cnt++; $display("FAIL prio_full: got count=%0d cready=%b exp 16/0", count, cmt_ready);
    end
    busy = 1'b0;
    for (int d = 0; d < 5; d++) begin
      #1;
      vec_cnt++;
      if ({rls, rp, count} !== {exp_v[d], exp_p[d], exp_c[d]}) begin
        err_cnt++;
        $display("FAIL prio_drain_%0d: got %b/%h/%0d exp %b/%h/%0d", d, rls, rp, count, exp_v[d], exp_p[d], exp_c[d]);
      end
      if (d == 0) begin
        vec_cnt++;
        if (cmt_ready !== 1'b1) begin
          err_cnt++; $display("FAIL prio_retry: got %b exp 1", cmt_ready);
        end
      end
      tick(); clear_inputs();
    end
    #1;
    vec_cnt++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      err_cnt++; $display("FAIL prio_done: got count=%0d empty=%b exp 0/1", count, empty);
    end
  endtask

  task automatic test_busy_gating();
    busy = 1'b1;
    push_cmt(4'b0111, pk(7, 8, 9, 0));
    vec_cnt++;
    if ({count, rls} !== {5'd3, 4'b0}) begin
      err_cnt++; $display("FAIL busy_hold: got count=%0d rls=%b exp 3/0000", count, rls);
    end
    tick(); #1;
    vec_cnt++;
    if ({count, rls} !== {5'd3, 4'b0}) begin
      err_cnt++; $display("FAIL busy_hold2: got count=%0d rls=%b exp 3/0000", count, rls);
    end
    busy = 1'b0;
    #1;
    vec_cnt++;
    if ({rls, rp} !== {4'b0111, pk(7, 8, 9, 0)}) begin
      err_cnt++; $display("FAIL busy_release: got %b/%h exp 0111/%h", rls, rp, pk(7, 8, 9, 0));
    end
    tick(); #1;
    vec_cnt++;
    if (count !== 5'd0) begin
      err_cnt++; $display("FAIL busy_count0: got %0d exp 0", count);
    end
  endtask

  task automatic test_reset_mid();
    busy = 1'b1;
    push_cmt(4'b1111, pk(21, 22, 23, 24));
    push_cmt(4'b1111, pk(25, 26, 27, 28));
    push_cmt(4'b0001, pk(29, 0, 0, 0));
    busy = 1'b0;
    #1;
    vec_cnt++;
    if ({count, rls, rp} !== {5'd9, 4'b1111, pk(21, 22, 23, 24)}) begin
      err_cnt++; $display("FAIL mid_pre: got %0d/%b/%h exp 9/1111/%h", count, rls, rp, pk(21, 22, 23, 24));
    end
    reset = 1'b1;
    #1;
    vec_cnt++;
    if ({rls, rp, count, empty} !== {4'b0, 24'b0, 5'd0, 1'b1}) begin
      err_cnt++;
      $display("FAIL mid_reset: got rls=%b pidx=%h count=%0d empty=%b exp 0/0/0/1", rls, rp, count, empty);
    end
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({rb_ready, cmt_ready} !== 2'b11) begin
      err_cnt++; $display("FAIL mid_ready: got %b exp 11", {rb_ready, cmt_ready});
    end
    tick(); #1;
    vec_cnt++;
    if ({count, empty, rls} !== {5'd0, 1'b1, 4'b0}) begin
      err_cnt++; $display("FAIL mid_after: got count=%0d empty=%b rls=%b exp 0/1/0000", count, empty, rls);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    tick();
    test_dense_commit();
    tick();
    test_sparse_merge();
    tick();
    test_fill_wrap();
    tick();
    test_priority();
    tick();
    test_busy_gating();
    tick();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
